leds_led_pwm: RTL and testbench

// - Downstream of the 1-bit LED PIO: consumes its out_port as led_in and drives the physical LED pin.
// - Output styles: pass-through, PWM dimming, timed blink. led_in gates every style.
// - Configured over its own Avalon-MM slave, with the same zero-wait-state read/write timing as the PIO.

---
 rtl/leds_pkg.sv | 23 ++
 rtl/leds_tick_gen.sv | 29 ++
 rtl/leds_led_pwm.sv | 190 +++++++++++++++++++
 tb/tb_leds_led_pwm.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/leds_pkg.sv
// Shared constants for the LED output stage: register map, MODE encodings
// and the blink state encoding.
package leds_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_DUTY     = 3'd1;
    localparam logic [2:0] ADDR_ON_LEN   = 3'd2;
    localparam logic [2:0] ADDR_OFF_LEN  = 3'd3;
    localparam logic [2:0] ADDR_PRESCALE = 3'd4;
    localparam logic [2:0] ADDR_STATUS   = 3'd5;

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_PWM   = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_OFF   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } blink_state_t;

endpackage

// File: rtl/leds_tick_gen.sv
// Blink prescaler: one-clk tick every prescale+1 clocks while enabled,
// counter held at zero while disabled.
module leds_tick_gen #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [TICK_W-1:0] prescale,
    output logic              tick
);

    logic [TICK_W-1:0] cnt;

    // >= rather than == so a PRESCALE lowered below the running count
    // wraps immediately instead of rolling through the full counter range.
    assign tick = en & (cnt >= prescale);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TICK_W'(1);
        end
    end

endmodule

// File: rtl/leds_led_pwm.sv
// LED output stage behind the LED PIO: pass-through, PWM dimming or timed
// blink of led_in, configured through a zero-wait-state Avalon-MM slave.
module leds_led_pwm
    import leds_pkg::*;
#(
    parameter int PWM_W   = 8,
    parameter int TICK_W  = 16,
    parameter int BLINK_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        led_in,
    output logic        led_out
);

    // Bus: a write is accepted on every posedge where chipselect=1 and
    // write_n=0 (no waitrequest); readdata follows address combinationally.
    logic wr;
    assign wr = chipselect & ~write_n;

    logic [2:0]         ctrl;
    logic [PWM_W-1:0]   duty;
    logic [BLINK_W-1:0] on_len;
    logic [BLINK_W-1:0] off_len;
    logic [TICK_W-1:0]  prescale;
    logic               unused_wdata;

    assign unused_wdata = ^writedata;

    logic       en;
    logic [1:0] mode;
    assign en   = ctrl[0];
    assign mode = ctrl[2:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            duty     <= '0;
            on_len   <= '0;
            off_len  <= '0;
            prescale <= '0;
        end else if (wr) begin
            case (address)
                ADDR_CTRL:     ctrl     <= writedata[2:0];
                ADDR_DUTY:     duty     <= writedata[PWM_W-1:0];
                ADDR_ON_LEN:   on_len   <= writedata[BLINK_W-1:0];
                ADDR_OFF_LEN:  off_len  <= writedata[BLINK_W-1:0];
                ADDR_PRESCALE: prescale <= writedata[TICK_W-1:0];
                default: ;
            endcase
        end
    end

    logic tick;

    leds_tick_gen #(.TICK_W(TICK_W)) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .prescale (prescale),
        .tick     (tick)
    );

    // PWM: duty_act only changes at period start; while disabled the counter
    // sits at period start, so duty_act tracks DUTY then too.
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] duty_act;
    logic [PWM_W-1:0] duty_fwd;
    logic             pwm_on;

    assign duty_fwd = (wr && address == ADDR_DUTY) ? writedata[PWM_W-1:0] : duty;
    assign pwm_on   = (pwm_cnt < duty_act) | (&duty_act);

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt  <= '0;
            duty_act <= '0;
        end else if (!en) begin
            pwm_cnt  <= '0;
            duty_act <= duty_fwd;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (&pwm_cnt) begin
                duty_act <= duty_fwd;
            end
        end
    end

    blink_state_t       state, state_nxt;
    logic [BLINK_W-1:0] phase_cnt, phase_cnt_nxt;
    logic [BLINK_W-1:0] phase_len, phase_len_nxt;
    logic               blink_go;
    logic               phase_done;

    assign blink_go   = en & (mode == MODE_BLINK) & led_in;
    assign phase_done = (phase_len == '0) |
                        (tick & ((phase_cnt + BLINK_W'(1)) == phase_len));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            phase_len <= '0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_cnt_nxt;
            phase_len <= phase_len_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt;
        phase_len_nxt = phase_len;
        case (state)
            ST_IDLE: begin
                if (blink_go) begin
                    state_nxt     = ST_ON;
                    phase_len_nxt = on_len;
                    phase_cnt_nxt = '0;
                end
            end
            ST_ON: begin
                if (!blink_go) begin
                    state_nxt = ST_IDLE;
                end else if (phase_done) begin
                    state_nxt     = ST_OFF;
                    phase_len_nxt = off_len;
                    phase_cnt_nxt = '0;
                end else if (tick) begin
                    phase_cnt_nxt = phase_cnt + BLINK_W'(1);
                end
            end
            ST_OFF: begin
                if (!blink_go) begin
                    state_nxt = ST_IDLE;
                end else if (phase_done) begin
                    state_nxt     = ST_ON;
                    phase_len_nxt = on_len;
                    phase_cnt_nxt = '0;
                end else if (tick) begin
                    phase_cnt_nxt = phase_cnt + BLINK_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A zero-length ON phase keeps the LED dark, which also covers both
    // lengths zero while the FSM toggles.
    logic nxt;
    always_comb begin
        nxt = 1'b0;
        if (en) begin
            case (mode)
                MODE_PASS:  nxt = led_in;
                MODE_PWM:   nxt = led_in & pwm_on;
                MODE_BLINK: nxt = led_in & (state == ST_ON) & (phase_len != '0);
                default:    nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_out <= 1'b0;
        end else begin
            led_out <= nxt;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:     readdata = {29'b0, ctrl};
            ADDR_DUTY:     readdata = {{(32-PWM_W){1'b0}}, duty};
            ADDR_ON_LEN:   readdata = {{(32-BLINK_W){1'b0}}, on_len};
            ADDR_OFF_LEN:  readdata = {{(32-BLINK_W){1'b0}}, off_len};
            ADDR_PRESCALE: readdata = {{(32-TICK_W){1'b0}}, prescale};
            ADDR_STATUS:   readdata = {29'b0, led_out, state};
            default:       readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_leds_led_pwm.sv
// Directed bench for leds_led_pwm: register table plus hand-timed sequences
// for pass-through latency, PWM periods, blink phases and reset.
module tb_leds_led_pwm;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        led_in;
    logic        led_out;

    int n_checks = 0;
    int n_errors = 0;

    leds_led_pwm dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_in     (led_in),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d,
                             input logic cs, input logic wn);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = wn;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_write(a, d, 1'b1, 1'b0);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_led(input logic v, input string name);
        int k = 0;
        while (led_out !== v && k < 200) begin
            k++;
            @(negedge clk);
        end
        if (led_out !== v) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: timeout waiting for led_out=%0d", name, v);
        end
    endtask

    task automatic run_len(input logic v, output int n);
        n = 0;
        while (led_out === v && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_high(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (led_out === 1'b1) n++;
        end
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [1:0]  kind;   // 0 read only, 1 write, 2 write_n high, 3 chipselect low
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [31:0] rd;
        logic        prev;
        logic        pat[5];
        int          n;
        int          hi1, hi2;

        vecs[0]  = '{3'd0, 2'd1, 32'hFFFF_FFF6, 32'h6};
        vecs[1]  = '{3'd1, 2'd1, 32'h1234_56A5, 32'hA5};
        vecs[2]  = '{3'd2, 2'd1, 32'hFFFF_FABC, 32'hABC};
        vecs[3]  = '{3'd3, 2'd1, 32'h0000_1123, 32'h123};
        vecs[4]  = '{3'd4, 2'd1, 32'hDEAD_BEEF, 32'hBEEF};
        vecs[5]  = '{3'd5, 2'd1, 32'hFFFF_FFFF, 32'h0};
        vecs[6]  = '{3'd6, 2'd1, 32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{3'd7, 2'd1, 32'hFFFF_FFFF, 32'h0};
        vecs[8]  = '{3'd0, 2'd0, 32'h0, 32'h6};
        vecs[9]  = '{3'd1, 2'd0, 32'h0, 32'hA5};
        vecs[10] = '{3'd2, 2'd0, 32'h0, 32'hABC};
        vecs[11] = '{3'd3, 2'd0, 32'h0, 32'h123};
        vecs[12] = '{3'd4, 2'd0, 32'h0, 32'hBEEF};
        vecs[13] = '{3'd1, 2'd2, 32'h0000_0011, 32'hA5};
        vecs[14] = '{3'd2, 2'd3, 32'h0000_0022, 32'hABC};
        vecs[15] = '{3'd4, 2'd2, 32'h0000_0033, 32'hBEEF};
        vecs[16] = '{3'd0, 2'd3, 32'h0000_0001, 32'h6};

        // Reset with led_in high
        reset = 1'b1; led_in = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0; writedata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_led_out", {31'b0, led_out}, 32'h0);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("reset_read_addr%0d", a), rd, 32'h0);
        end

        // Register table
        for (int i = 0; i < 17; i++) begin
            case (vecs[i].kind)
                2'd1: bus_write(vecs[i].addr, vecs[i].wdata, 1'b1, 1'b0);
                2'd2: bus_write(vecs[i].addr, vecs[i].wdata, 1'b1, 1'b1);
                2'd3: bus_write(vecs[i].addr, vecs[i].wdata, 1'b0, 1'b0);
                default: ;
            endcase
            bus_read(vecs[i].addr, rd);
            check($sformatf("reg_vec%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
        end

        // Pass-through with one clk latency
        wr(3'd0, 32'd1);
        @(negedge clk);
        prev = 1'b1;
        pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b0; pat[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            led_in = pat[i];
            #1;
            check($sformatf("pass_hold%0d", i), {31'b0, led_out}, {31'b0, prev});
            @(negedge clk);
            check($sformatf("pass_follow%0d", i), {31'b0, led_out}, {31'b0, pat[i]});
            prev = pat[i];
        end
        wr(3'd0, 32'd7);
        @(negedge clk);
        check("forced_off", {31'b0, led_out}, 32'h0);

        // PWM: 64 high this period, DUTY=192 written mid-period takes the next
        wr(3'd0, 32'd0);
        wr(3'd1, 32'd64);
        led_in = 1'b1;
        wr(3'd0, 32'd3);
        hi1 = 0; hi2 = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (led_out === 1'b1) begin
                if (i < 256) hi1++;
                else hi2++;
            end
            if (i == 100) begin
                address = 3'd1; writedata = 32'd192; chipselect = 1'b1; write_n = 1'b0;
            end else if (i == 101) begin
                chipselect = 1'b0; write_n = 1'b1;
            end
        end
        check("pwm_period_duty64", 32'(hi1), 32'd64);
        check("pwm_period_duty192", 32'(hi2), 32'd192);
        wr(3'd1, 32'd0);
        repeat (256) @(negedge clk);
        count_high(256, n);
        check("pwm_duty0", 32'(n), 32'd0);
        wr(3'd1, 32'd255);
        repeat (256) @(negedge clk);
        count_high(256, n);
        check("pwm_duty255", 32'(n), 32'd256);

        // Blink: tick every 4 clk, 2 ticks on, 3 ticks off
        wr(3'd0, 32'd0);
        wr(3'd4, 32'd3);
        wr(3'd2, 32'd2);
        wr(3'd3, 32'd3);
        wr(3'd0, 32'd5);
        wait_led(1'b1, "blink_first_on");
        run_len(1'b1, n);
        run_len(1'b0, n);
        check("blink_low_a", 32'(n), 32'd12);
        run_len(1'b1, n);
        check("blink_high", 32'(n), 32'd8);
        run_len(1'b0, n);
        check("blink_low_b", 32'(n), 32'd12);
        wait_led(1'b1, "blink_on_again");
        bus_read(3'd5, rd);
        check("status_on", rd, 32'h5);
        led_in = 1'b0;
        @(negedge clk);
        check("drop_led_in", {31'b0, led_out}, 32'h0);
        bus_read(3'd5, rd);
        check("status_idle", rd, 32'h0);
        led_in = 1'b1;

        // ON_LEN=0: LED never lights
        wr(3'd0, 32'd0);
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd2);
        wr(3'd0, 32'd5);
        count_high(100, n);
        check("on_len0_dark", 32'(n), 32'd0);

        // OFF_LEN=0: one-clk gap; ON re-entered off-tick lasts 7 clk
        wr(3'd0, 32'd0);
        wr(3'd2, 32'd2);
        wr(3'd3, 32'd0);
        wr(3'd0, 32'd5);
        wait_led(1'b1, "off_len0_on");
        run_len(1'b1, n);
        run_len(1'b0, n);
        check("off_len0_gap_a", 32'(n), 32'd1);
        run_len(1'b1, n);
        check("off_len0_high", 32'(n), 32'd7);
        run_len(1'b0, n);
        check("off_len0_gap_b", 32'(n), 32'd1);

        // Reset mid-blink
        wait_led(1'b1, "pre_reset_on");
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_led", {31'b0, led_out}, 32'h0);
        reset = 1'b0;
        bus_read(3'd5, rd);
        check("reset_mid_status", rd, 32'h0);
        bus_read(3'd0, rd);
        check("reset_mid_ctrl", rd, 32'h0);
        bus_read(3'd2, rd);
        check("reset_mid_on_len", rd, 32'h0);
        @(negedge clk);
        check("reset_mid_led_after", {31'b0, led_out}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
